dpc_line_buffer: RTL and testbench
==================================

Name: dpc_line_buffer

Overview:
Raster-to-column line buffer that feeds the 3x3 DPC window generator.
- Accepts one pixel per valid cycle in raster order.
- Stores the two previous image rows.
- Emits three vertically aligned taps per accepted pixel: the current row plus rows r-1 and r-2. These drive the window's three row inputs directly, with out_valid driving its in_valid.
- Also provides top-edge replication, and column/row position and end-of-line/end-of-frame flags for downstream border logic.

Parameters:
WIDTH, 8, pixel bit width
IMG_WIDTH, 640, pixels per line (>=2); line memory depth
IMG_HEIGHT, 512, lines per frame (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  pixel qualifier; in_data/in_sof sampled only when high
in_sof  input  1  first pixel of frame (row 0, col 0); valid only with in_valid
in_data  input  WIDTH  raster pixel
out_valid  output  1  taps valid, one pulse per accepted pixel
w1_out  output  WIDTH  current-row pixel (row r), feeds window row-1 input
w2_out  output  WIDTH  row r-1 pixel at the same column
w3_out  output  WIDTH  row r-2 pixel at the same column
out_col  output  clog2(IMG_WIDTH)  column of the emitted taps
out_row  output  clog2(IMG_HEIGHT)  row of the emitted taps
out_eol  output  1  emitted pixel is the last in its line
out_eof  output  1  emitted pixel is the last in the frame

Behaviour:
Interface (decided): one clock, clk; reset rst is synchronous and active-high.

Reset:
- out_valid, out_eol, out_eof = 0.
- w1_out/w2_out/w3_out/out_col/out_row = 0.
- col/row counters = 0; FSM = WAIT_SOF.
- Line memories are not cleared; stale contents are masked by row gating.

FSM:
- WAIT_SOF: accepted pixels without in_sof are dropped (out_valid stays 0). in_valid & in_sof -> process the pixel as (row 0, col 0), go to ACTIVE.
- ACTIVE: each in_valid pixel is processed at the current (row, col).
  - col == IMG_WIDTH-1 -> col = 0, row++.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) -> counters clear, return to WAIT_SOF.
  - in_valid & in_sof in ACTIVE (early restart) -> pixel is treated as (0, 0); counters restart; stay in ACTIVE.

Per accepted pixel at column c:
- Read mem_a[c] (row r-1) and mem_b[c] (row r-2).
- Same cycle: mem_a[c] <= in_data, mem_b[c] <= old mem_a[c] (read-before-write).
- Latency is exactly 1 cycle; all outputs are registered.
- w1_out = in_data.
- w2_out = (row >= 1) ? old mem_a[c] : in_data.
- w3_out = (row >= 2) ? old mem_b[c] : w2_out value. This gives top-edge replication.
- out_col/out_row = position of this pixel.
- out_eol = (c == IMG_WIDTH-1).
- out_eof = out_eol & (r == IMG_HEIGHT-1).

Other rules:
- in_valid low: no memory write, no counter change, out_valid = 0 next cycle. Data, position and flag outputs hold their last values; eol/eof are qualified by out_valid only.
- Back-to-back valids sustain one output per cycle; no stall or backpressure exists.
- Reset mid-frame: next cycle is in reset state; the next frame requires in_sof.
- in_sof when in_valid is low: ignored.
- Counters never exceed IMG_WIDTH-1 / IMG_HEIGHT-1.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=3; sof then pixels 1..12 continuous. Required outputs:
   - Row 0 taps (1,1,1)..(4,4,4).
   - Row 1 taps (5,1,1)..(8,4,4).
   - Row 2 taps (9,5,1)..(12,8,4).
   - out_eol on pixels 4, 8, 12; out_eof only on 12.
   - Each output 1 cycle after its input.
2. Same frame with in_valid toggling 1-0-1-0 -> identical tap sequence. out_valid appears only on cycles following valid inputs; held outputs are unchanged during gaps.
3. Pixels 50..53 without sof, then frame of test 1 -> 50..53 produce no out_valid; frame output matches test 1.
4. Two consecutive frames (second frame pixels 101..112) -> second frame row 0 taps are (101,101,101), not stale data from the first frame; row 2 col 0 is (109,105,101).
5. Mid-frame restart: sof asserted at row 1 col 2 with data 200 -> emitted as row 0, col 0 taps (200,200,200); subsequent rows are replicated from the new frame.
6. rst asserted at row 2 col 1, then sof frame 1..12 -> all outputs 0 and out_valid 0 during reset; the new frame matches test 1 exactly.

Source files
------------

// File: rtl/dpc_line_buffer.sv
// Raster-to-column line buffer for the 3x3 DPC window generator.
// Keeps the two previous image rows in line memories and emits, one cycle
// after each accepted pixel, three vertically aligned taps (rows r, r-1, r-2)
// with top-edge replication, plus the pixel position and end-of-line/frame flags.
module dpc_line_buffer #(
    parameter int WIDTH      = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              w1_out,
    output logic [WIDTH-1:0]              w2_out,
    output logic [WIDTH-1:0]              w3_out,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic                          out_eol,
    output logic                          out_eof
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t state;

    // Position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // mem_a holds row r-1, mem_b holds row r-2 (not reset; masked by row gating).
    logic [WIDTH-1:0] mem_a [IMG_WIDTH];
    logic [WIDTH-1:0] mem_b [IMG_WIDTH];

    logic             accept;
    logic [CW-1:0]    pos_col;
    logic [RW-1:0]    pos_row;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] tap2;
    logic [WIDTH-1:0] tap3;
    logic             at_eol;
    logic             at_eof;

    // Decide acceptance, resolve the pixel position (sof forces 0,0) and form the taps.
    always_comb begin
        accept  = in_valid && (in_sof || (state == ACTIVE));
        pos_col = in_sof ? '0 : col;
        pos_row = in_sof ? '0 : row;
        rd_a    = mem_a[pos_col];
        rd_b    = mem_b[pos_col];
        // Rows above the frame top are replaced by the nearest real row.
        tap2    = (pos_row != '0) ? rd_a : in_data;
        tap3    = (pos_row > RW'(1)) ? rd_b : tap2;
        at_eol  = (pos_col == COL_LAST);
        at_eof  = at_eol && (pos_row == ROW_LAST);
    end

    // Frame FSM, position counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_SOF;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            w1_out    <= '0;
            w2_out    <= '0;
            w3_out    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                w1_out  <= in_data;
                w2_out  <= tap2;
                w3_out  <= tap3;
                out_col <= pos_col;
                out_row <= pos_row;
                out_eol <= at_eol;
                out_eof <= at_eof;
                if (at_eof) begin
                    col   <= '0;
                    row   <= '0;
                    state <= WAIT_SOF;
                end else if (at_eol) begin
                    col   <= '0;
                    row   <= pos_row + RW'(1);
                    state <= ACTIVE;
                end else begin
                    col   <= pos_col + CW'(1);
                    row   <= pos_row;
                    state <= ACTIVE;
                end
            end
        end
    end

    // Line memory update: read-before-write shifts row r-1 down into the r-2 store.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_a[pos_col] <= in_data;
            mem_b[pos_col] <= rd_a;
        end
    end

endmodule

// File: tb/tb_dpc_line_buffer.sv
// Directed table-driven bench for dpc_line_buffer on a 4x3 image.
module tb_dpc_line_buffer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] w1_out;
    logic [7:0] w2_out;
    logic [7:0] w3_out;
    logic [1:0] out_col;
    logic [1:0] out_row;
    logic       out_eol;
    logic       out_eof;

    dpc_line_buffer #(
        .WIDTH      (8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .w1_out    (w1_out),
        .w2_out    (w2_out),
        .w3_out    (w3_out),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic       rst;
        logic       vld;
        logic       sof;
        logic [7:0] data;
        logic       ov;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [7:0] w3;
        logic [1:0] col;
        logic [1:0] row;
        logic       eol;
        logic       eof;
    } vec_t;

    vec_t vecs[$];

    // Expected values of the held outputs.
    logic [7:0] h_w1, h_w2, h_w3;
    logic [1:0] h_col, h_row;
    logic       h_eol, h_eof;

    int tests_run = 0;
    int tests_failed = 0;

    // Append one cycle; acc says whether the pixel is accepted at (row, col).
    // Frames use consecutive values, so the pixel above is value - 4.
    task automatic push(input int tag, input logic r, input logic v, input logic s,
                        input logic [7:0] d, input bit acc, input int prow, input int pcol);
        vec_t x;
        if (r) begin
            h_w1 = '0; h_w2 = '0; h_w3 = '0;
            h_col = '0; h_row = '0; h_eol = 1'b0; h_eof = 1'b0;
        end else if (acc) begin
            h_w1  = d;
            h_w2  = (prow >= 1) ? d - 8'd4 : d;
            h_w3  = (prow >= 2) ? d - 8'd8 : h_w2;
            h_col = 2'(pcol);
            h_row = 2'(prow);
            h_eol = (pcol == 3);
            h_eof = (pcol == 3) && (prow == 2);
        end
        x.tag = tag; x.rst = r; x.vld = v; x.sof = s; x.data = d;
        x.ov = acc && !r;
        x.w1 = h_w1; x.w2 = h_w2; x.w3 = h_w3;
        x.col = h_col; x.row = h_row; x.eol = h_eol; x.eof = h_eof;
        vecs.push_back(x);
    endtask

    // n pixels of a frame starting at value first; gaps inserts an idle cycle
    // (with a stray sof that must be ignored) after each pixel.
    task automatic add_frame(input int tag, input int first, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            push(tag, 1'b0, 1'b1, (i == 0), 8'(first + i), 1'b1, i / 4, i % 4);
            if (gaps) push(tag, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;

        // Reset state.
        push(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
        push(0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 0, 0);
        // 1: continuous frame.
        add_frame(1, 1, 12, 1'b0);
        // 2: same frame with idle cycles between pixels.
        add_frame(2, 1, 12, 1'b1);
        // 3: pixels without sof are dropped; sof with valid low is ignored.
        for (int i = 0; i < 4; i++) push(3, 1'b0, 1'b1, 1'b0, 8'(50 + i), 1'b0, 0, 0);
        push(3, 1'b0, 1'b0, 1'b1, 8'd77, 1'b0, 0, 0);
        push(3, 1'b0, 1'b1, 1'b0, 8'd78, 1'b0, 0, 0);
        add_frame(3, 1, 12, 1'b0);
        // 4: second frame directly after; row 0 must not show stale rows.
        add_frame(4, 101, 12, 1'b0);
        // 5: restart with sof at row 1 col 2.
        add_frame(5, 1, 6, 1'b0);
        add_frame(5, 200, 12, 1'b0);
        // 6: reset at row 2 col 1, then a fresh frame.
        add_frame(6, 1, 9, 1'b0);
        push(6, 1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 0, 0);
        push(6, 1'b1, 1'b0, 1'b0, 8'd11, 1'b0, 0, 0);
        push(6, 1'b0, 1'b1, 1'b0, 8'd12, 1'b0, 0, 0);
        add_frame(6, 1, 12, 1'b0);

        foreach (vecs[k]) begin
            rst      = vecs[k].rst;
            in_valid = vecs[k].vld;
            in_sof   = vecs[k].sof;
            in_data  = vecs[k].data;
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== vecs[k].ov || w1_out !== vecs[k].w1 ||
                w2_out !== vecs[k].w2 || w3_out !== vecs[k].w3 ||
                out_col !== vecs[k].col || out_row !== vecs[k].row ||
                out_eol !== vecs[k].eol || out_eof !== vecs[k].eof) begin
                tests_failed++;
                $display("FAIL t%0d vec%0d: got v=%b taps=(%0d,%0d,%0d) r=%0d c=%0d eol=%b eof=%b, want v=%b taps=(%0d,%0d,%0d) r=%0d c=%0d eol=%b eof=%b",
                         vecs[k].tag, k, out_valid, w1_out, w2_out, w3_out, out_row, out_col,
                         out_eol, out_eof, vecs[k].ov, vecs[k].w1, vecs[k].w2, vecs[k].w3,
                         vecs[k].row, vecs[k].col, vecs[k].eol, vecs[k].eof);
            end
        end

        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || w1_out !== 8'd12 || out_eof !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_hold: got v=%b w1=%0d eof=%b, want v=0 w1=12 eof=1",
                     out_valid, w1_out, out_eof);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
